// File: rtl/swerv_types.sv
// Shared SweRV types: retire-trace packet from the core and per-instruction trace record.
package swerv_types;

    localparam int unsigned TRACE_LANES = 3;
    localparam int unsigned LANE_CNT_W  = 2;

    typedef struct packed {
        logic [TRACE_LANES*32-1:0] trace_rv_i_insn_ip;
        logic [TRACE_LANES*32-1:0] trace_rv_i_address_ip;
        logic [TRACE_LANES-1:0]    trace_rv_i_valid_ip;
        logic [TRACE_LANES-1:0]    trace_rv_i_exception_ip;
        logic [4:0]                trace_rv_i_ecause_ip;
        logic [TRACE_LANES-1:0]    trace_rv_i_interrupt_ip;
        logic [31:0]               trace_rv_i_tval_ip;
    } trace_pkt_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic [1:0]  lane;
        logic        exception;
        logic        interrupt;
        logic [4:0]  ecause;
        logic [31:0] tval;
    } trace_rec_t;

    // Number of retiring lanes in a packet.
    function automatic logic [LANE_CNT_W-1:0] lane_count(input logic [TRACE_LANES-1:0] v);
        logic [LANE_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(TRACE_LANES); i++) begin
            n = n + LANE_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/trace_mw_fifo.sv
// Multi-write, single-read FIFO: valid write ports are packed contiguously in port order.
module trace_mw_fifo #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WIDTH    = 105,
    parameter int unsigned WR_PORTS = 3
) (
    input  logic                               clk,
    input  logic                               rst_l,
    input  logic                               wr_en,
    input  logic [WR_PORTS-1:0]                wr_valid,
    input  logic [WR_PORTS-1:0][WIDTH-1:0]     wr_data,
    input  logic                               rd_en,
    output logic [WIDTH-1:0]                   rd_data,
    output logic [$clog2(DEPTH):0]             count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OFF_W = $clog2(WR_PORTS + 1);

    logic [WIDTH-1:0]                mem_q [DEPTH];
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [WR_PORTS-1:0][PTR_W-1:0]  wr_idx;
    logic [WR_PORTS-1:0]             wr_fire;
    logic [OFF_W-1:0]                wr_n;
    logic                            pop;

    // Each valid port lands at wr_ptr plus the number of valid ports below it.
    always_comb begin
        wr_n    = '0;
        wr_idx  = '0;
        wr_fire = '0;
        for (int i = 0; i < int'(WR_PORTS); i++) begin
            wr_idx[i]  = wr_ptr_q + PTR_W'(wr_n);
            wr_fire[i] = wr_en & wr_valid[i];
            if (wr_valid[i]) begin
                wr_n = wr_n + OFF_W'(1);
            end
        end
        pop      = rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q + (wr_en ? PTR_W'(wr_n) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (wr_en ? CNT_W'(wr_n) : CNT_W'(0)) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(WR_PORTS); i++) begin
            if (wr_fire[i]) begin
                mem_q[wr_idx[i]] <= wr_data[i];
            end
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/trace_pkt_serializer.sv
// Splits retire-trace packets into per-instruction records and streams them out one per cycle.
module trace_pkt_serializer
    import swerv_types::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  trace_pkt_t                trace_pkt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output trace_rec_t                out_rec,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_cnt,
    input  logic                      clr_overflow
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam int unsigned REC_W = $bits(trace_rec_t);

    trace_rec_t [TRACE_LANES-1:0] lane_rec;
    logic [LANE_CNT_W-1:0]        n_lanes;
    logic [OCC_W-1:0]             free_slots;
    logic                         accept;
    logic                         drop;
    logic                         overflow_q, overflow_d;
    logic [CNT_W-1:0]             drop_cnt_q, drop_cnt_d;
    logic [REC_W-1:0]             head_data;

    // Per-lane records; cause/tval are only meaningful on trapping lanes.
    always_comb begin
        lane_rec = '0;
        for (int i = 0; i < int'(TRACE_LANES); i++) begin
            lane_rec[i].insn      = trace_pkt.trace_rv_i_insn_ip[32*i +: 32];
            lane_rec[i].addr      = trace_pkt.trace_rv_i_address_ip[32*i +: 32];
            lane_rec[i].lane      = 2'(i);
            lane_rec[i].exception = trace_pkt.trace_rv_i_exception_ip[i];
            lane_rec[i].interrupt = trace_pkt.trace_rv_i_interrupt_ip[i];
            if (trace_pkt.trace_rv_i_exception_ip[i] || trace_pkt.trace_rv_i_interrupt_ip[i]) begin
                lane_rec[i].ecause = trace_pkt.trace_rv_i_ecause_ip;
                lane_rec[i].tval   = trace_pkt.trace_rv_i_tval_ip;
            end
        end
    end

    // Whole-packet admission against occupancy at the start of the cycle; a pop gives no credit.
    always_comb begin
        n_lanes    = lane_count(trace_pkt.trace_rv_i_valid_ip);
        free_slots = OCC_W'(DEPTH) - fifo_count;
        accept     = (n_lanes != '0) && (OCC_W'(n_lanes) <= free_slots);
        drop       = (n_lanes != '0) && !accept;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow) begin
                drop_cnt_d = CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    trace_mw_fifo #(
        .DEPTH    (DEPTH),
        .WIDTH    (REC_W),
        .WR_PORTS (TRACE_LANES)
    ) u_fifo (
        .clk      (clk),
        .rst_l    (rst_l),
        .wr_en    (accept),
        .wr_valid (trace_pkt.trace_rv_i_valid_ip),
        .wr_data  (lane_rec),
        .rd_en    (out_ready),
        .rd_data  (head_data),
        .count    (fifo_count)
    );

    assign out_rec   = trace_rec_t'(head_data);
    assign out_valid = (fifo_count != '0);
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_trace_pkt_serializer.sv
// Bench for trace_pkt_serializer: directed scenarios plus random traffic against a queue model.
module tb_trace_pkt_serializer;
    import swerv_types::*;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned OCC_W     = $clog2(DEPTH) + 1;
    localparam int unsigned DCNT_MAX  = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_l;
    trace_pkt_t         pkt;
    logic               out_valid;
    logic               out_ready;
    trace_rec_t         out_rec;
    logic [OCC_W-1:0]   fifo_count;
    logic               overflow;
    logic [CNT_W-1:0]   drop_cnt;
    logic               clr_overflow;

    int          n_cmp;
    int          n_bad;
    trace_rec_t  mq[$];
    bit          m_ovf;
    int unsigned m_dcnt;
    int unsigned exp_next;

    trace_pkt_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .trace_pkt    (pkt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rec      (out_rec),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic trace_rec_t model_rec(input int l);
        trace_rec_t r;
        r.insn      = pkt.trace_rv_i_insn_ip[32*l +: 32];
        r.addr      = pkt.trace_rv_i_address_ip[32*l +: 32];
        r.lane      = 2'(l);
        r.exception = pkt.trace_rv_i_exception_ip[l];
        r.interrupt = pkt.trace_rv_i_interrupt_ip[l];
        if (r.exception || r.interrupt) begin
            r.ecause = pkt.trace_rv_i_ecause_ip;
            r.tval   = pkt.trace_rv_i_tval_ip;
        end else begin
            r.ecause = '0;
            r.tval   = '0;
        end
        return r;
    endfunction

    // Reference behaviour at one clock edge, from the packet/queue rules.
    task automatic model_edge();
        int n;
        int free;
        bit pop;
        bit drop;
        n    = $countones(pkt.trace_rv_i_valid_ip);
        free = int'(DEPTH) - mq.size();
        pop  = (mq.size() != 0) && out_ready;
        drop = (n != 0) && (n > free);
        if (pop) void'(mq.pop_front());
        if (n != 0 && !drop) begin
            for (int l = 0; l < 3; l++) begin
                if (pkt.trace_rv_i_valid_ip[l]) mq.push_back(model_rec(l));
            end
        end
        if (drop) begin
            m_ovf  = 1'b1;
            m_dcnt = clr_overflow ? 1 : ((m_dcnt == DCNT_MAX) ? m_dcnt : m_dcnt + 1);
        end else if (clr_overflow) begin
            m_ovf  = 1'b0;
            m_dcnt = 0;
        end
    endtask

    task automatic compare_all(input string ph);
        check_eq({ph, "_valid"}, 128'(out_valid), 128'(mq.size() != 0));
        check_eq({ph, "_count"}, 128'(fifo_count), 128'(mq.size()));
        if (mq.size() != 0) check_eq({ph, "_rec"}, 128'(out_rec), 128'(mq[0]));
        check_eq({ph, "_ovf"}, 128'(overflow), 128'(m_ovf));
        check_eq({ph, "_dcnt"}, 128'(drop_cnt), 128'(m_dcnt));
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(ph);
    endtask

    task automatic set_pkt(input logic [2:0] v, input logic [95:0] insn, input logic [95:0] addr,
                           input logic [2:0] exc, input logic [2:0] intr,
                           input logic [4:0] ec, input logic [31:0] tv);
        pkt.trace_rv_i_valid_ip     = v;
        pkt.trace_rv_i_insn_ip      = insn;
        pkt.trace_rv_i_address_ip   = addr;
        pkt.trace_rv_i_exception_ip = exc;
        pkt.trace_rv_i_interrupt_ip = intr;
        pkt.trace_rv_i_ecause_ip    = ec;
        pkt.trace_rv_i_tval_ip      = tv;
    endtask

    task automatic drain();
        pkt.trace_rv_i_valid_ip = '0;
        out_ready    = 1'b1;
        clr_overflow = 1'b0;
        repeat (DEPTH + 1) tick("drain");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_ovf = 1'b0;
        m_dcnt = 0;
        rst_l = 1'b0;
        pkt = '0;
        out_ready = 1'b0;
        clr_overflow = 1'b0;
        repeat (2) @(negedge clk);
        compare_all("reset");
        check_eq("reset_valid", 128'(out_valid), 128'(0));
        check_eq("reset_count", 128'(fifo_count), 128'(0));
        rst_l = 1'b1;

        // Single lane, one-cycle latency.
        set_pkt(3'b001, {64'h0, 32'h0000_0013}, {64'h0, 32'h8000_0000}, 3'b000, 3'b000, 5'd0, 32'h0);
        out_ready = 1'b1;
        tick("single");
        check_eq("single_vld", 128'(out_valid), 128'(1));
        check_eq("single_insn", 128'(out_rec.insn), 128'(32'h13));
        check_eq("single_addr", 128'(out_rec.addr), 128'(32'h8000_0000));
        check_eq("single_lane", 128'(out_rec.lane), 128'(0));
        check_eq("single_tval", 128'(out_rec.tval), 128'(0));
        pkt.trace_rv_i_valid_ip = '0;
        tick("single_b");
        check_eq("single_empty", 128'(out_valid), 128'(0));

        // Sparse compaction.
        out_ready = 1'b0;
        set_pkt(3'b101, {32'hC, 32'hB, 32'hA}, {32'h108, 32'h104, 32'h100}, 3'b000, 3'b000, 5'd0, 32'h0);
        tick("sparse");
        check_eq("sparse_count", 128'(fifo_count), 128'(2));
        check_eq("sparse_h0", 128'(out_rec.insn), 128'(32'hA));
        pkt.trace_rv_i_valid_ip = '0;
        out_ready = 1'b1;
        tick("sparse_b");
        check_eq("sparse_h1", 128'(out_rec.insn), 128'(32'hC));
        check_eq("sparse_lane", 128'(out_rec.lane), 128'(2));
        tick("sparse_c");

        // Exception lane gets cause/tval, the other lane does not.
        out_ready = 1'b0;
        set_pkt(3'b011, {32'h3, 32'h2, 32'h1}, {32'h208, 32'h204, 32'h200}, 3'b010, 3'b000, 5'd2, 32'hDEAD_BEEF);
        tick("exc");
        check_eq("exc_l0_ecause", 128'(out_rec.ecause), 128'(0));
        check_eq("exc_l0_tval", 128'(out_rec.tval), 128'(0));
        pkt.trace_rv_i_valid_ip = '0;
        out_ready = 1'b1;
        tick("exc_b");
        check_eq("exc_l1_exc", 128'(out_rec.exception), 128'(1));
        check_eq("exc_l1_ecause", 128'(out_rec.ecause), 128'(2));
        check_eq("exc_l1_tval", 128'(out_rec.tval), 128'(32'hDEAD_BEEF));
        drain();

        // Overflow with back-pressure.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_pkt(3'b111, {$urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom()},
                    3'b000, 3'b000, 5'd0, 32'h0);
            tick("ovf");
        end
        check_eq("ovf_count", 128'(fifo_count), 128'(6));
        check_eq("ovf_flag", 128'(overflow), 128'(1));
        check_eq("ovf_dcnt", 128'(drop_cnt), 128'(2));

        // Full: pop gives no credit; drop beats clear.
        set_pkt(3'b011, {$urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom()},
                3'b000, 3'b000, 5'd0, 32'h0);
        tick("fill");
        check_eq("full_count", 128'(fifo_count), 128'(8));
        set_pkt(3'b001, {$urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom()},
                3'b000, 3'b000, 5'd0, 32'h0);
        out_ready = 1'b1;
        clr_overflow = 1'b1;
        tick("full_pop");
        check_eq("full_pop_count", 128'(fifo_count), 128'(7));
        check_eq("full_pop_ovf", 128'(overflow), 128'(1));
        check_eq("full_pop_dcnt", 128'(drop_cnt), 128'(1));
        pkt.trace_rv_i_valid_ip = '0;
        out_ready = 1'b0;
        tick("clr");
        check_eq("clr_ovf", 128'(overflow), 128'(0));
        check_eq("clr_dcnt", 128'(drop_cnt), 128'(0));
        drain();

        // Random traffic with varying back-pressure.
        for (int blk = 0; blk < 15; blk++) begin
            int rdy_pct;
            rdy_pct = int'($urandom_range(10, 100));
            for (int c = 0; c < 200; c++) begin
                set_pkt(3'($urandom_range(0, 7)),
                        {$urandom(), $urandom(), $urandom()},
                        {$urandom(), $urandom(), $urandom()},
                        3'($urandom()) & 3'($urandom()) & 3'($urandom()),
                        3'($urandom()) & 3'($urandom()) & 3'($urandom()),
                        5'($urandom()), $urandom());
                out_ready    = (int'($urandom_range(1, 100)) <= rdy_pct);
                clr_overflow = ($urandom_range(0, 63) == 0);
                tick("rnd");
            end
        end
        drain();

        // Pointer wrap: 20 single-lane packets streamed straight through.
        exp_next = 1;
        out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            set_pkt(3'b001, {64'h0, 32'(k)}, {64'h0, 32'h8000_0000 + 32'(4 * k)}, 3'b000, 3'b000, 5'd0, 32'h0);
            tick("wrap");
            if (out_valid) begin
                check_eq("wrap_order", 128'(out_rec.insn), 128'(exp_next));
                exp_next++;
            end
        end
        check_eq("wrap_total", 128'(exp_next), 128'(21));
        pkt.trace_rv_i_valid_ip = '0;
        tick("wrap_end");

        // Asynchronous reset with records buffered.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_pkt(3'b001, {64'h0, 32'(100 + k)}, {64'h0, 32'h9000_0000}, 3'b000, 3'b000, 5'd0, 32'h0);
            tick("prerst");
        end
        check_eq("prerst_count", 128'(fifo_count), 128'(5));
        #2;
        rst_l = 1'b0;
        pkt.trace_rv_i_valid_ip = '0;
        #1;
        check_eq("arst_valid", 128'(out_valid), 128'(0));
        check_eq("arst_count", 128'(fifo_count), 128'(0));
        mq.delete();
        m_ovf = 1'b0;
        m_dcnt = 0;
        @(negedge clk);
        rst_l = 1'b1;
        compare_all("post_rst");
        set_pkt(3'b111, {32'h33, 32'h22, 32'h11}, {32'h8, 32'h4, 32'h0}, 3'b000, 3'b100, 5'd7, 32'h1234);
        out_ready = 1'b1;
        tick("post_rst_a");
        pkt.trace_rv_i_valid_ip = '0;
        repeat (4) tick("post_rst_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
